// File: rtl/mips_cpu_hilo_pkg.sv
// Shared types and constants for the HI/LO sequencer.
// Optional feature macro: MIPS_CPU_MADD_EN adds MADD/MADDU/MSUB/MSUBU opcodes
// and widens the opcode field to 4 bits.
package mips_cpu_hilo_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned DIV_CNT_W = 6;

`ifdef MIPS_CPU_MADD_EN
    localparam int unsigned OP_W = 4;
`else
    localparam int unsigned OP_W = 3;
`endif

    typedef enum logic [OP_W-1:0] {
        MULT  = OP_W'(0),
        MULTU = OP_W'(1),
        DIV   = OP_W'(2),
        DIVU  = OP_W'(3),
        MTHI  = OP_W'(4),
        MTLO  = OP_W'(5),
        MFHI  = OP_W'(6),
        MFLO  = OP_W'(7)
`ifdef MIPS_CPU_MADD_EN
        ,
        MADD  = OP_W'(8),
        MADDU = OP_W'(9),
        MSUB  = OP_W'(10),
        MSUBU = OP_W'(11)
`endif
    } hilo_op_t;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MUL_WAIT = 2'd1,
        DIV_RUN  = 2'd2,
        DIV_FIN  = 2'd3
    } hilo_state_t;

    // Magnitude of v when treated as signed; v unchanged for unsigned ops.
    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic sgn);
        return (sgn && v[XLEN-1]) ? -v : v;
    endfunction

endpackage

// File: rtl/mips_cpu_hilo_ctrl_if.sv
// Request bus between the execute stage (master) and the HI/LO sequencer (slave).
//   req_valid/req_ready : handshake, accept = req_valid & req_ready
//   req_op              : hilo_op_t opcode
//   rs_val/rt_val       : operands
//   rd_data             : MFHI/MFLO result in the accept cycle
//   done                : one-cycle pulse when a MULT*/DIV* op writes HI/LO
interface mips_cpu_hilo_ctrl_if;
    import mips_cpu_hilo_pkg::*;

    logic            req_valid;
    logic            req_ready;
    hilo_op_t        req_op;
    logic [XLEN-1:0] rs_val;
    logic [XLEN-1:0] rt_val;
    logic [XLEN-1:0] rd_data;
    logic            done;

    modport master (
        output req_valid, req_op, rs_val, rt_val,
        input  req_ready, rd_data, done
    );

    modport slave (
        input  req_valid, req_op, rs_val, rt_val,
        output req_ready, rd_data, done
    );

endinterface

// File: rtl/mips_cpu_divider.sv
// Unsigned restoring divider, one quotient bit per cycle.
//   clk, rst_n : clock, async active-low reset
//   start      : load a (dividend) and b (divisor), begin DIV_BITS iterations
//   q, r       : quotient / remainder, final once valid is high
//   valid      : high from the edge that completes the last iteration until next start
module mips_cpu_divider
    import mips_cpu_hilo_pkg::*;
#(
    parameter int unsigned DIV_BITS = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic [XLEN-1:0] q,
    output logic [XLEN-1:0] r,
    output logic            valid
);

    logic [XLEN-1:0]      rem_q;
    logic [XLEN-1:0]      quo_q;
    logic [XLEN-1:0]      dvs_q;
    logic [DIV_CNT_W-1:0] cnt_q;
    logic                 valid_q;
    logic [XLEN:0]        shifted;
    logic [XLEN:0]        diff;

    // Trial subtraction; a set borrow bit means the divisor did not fit.
    always_comb begin
        shifted = {rem_q, quo_q[XLEN-1]};
        diff    = shifted - {1'b0, dvs_q};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else if (start) begin
            rem_q   <= '0;
            quo_q   <= a;
            dvs_q   <= b;
            cnt_q   <= DIV_CNT_W'(DIV_BITS);
            valid_q <= 1'b0;
        end else if (cnt_q != '0) begin
            rem_q   <= diff[XLEN] ? shifted[XLEN-1:0] : diff[XLEN-1:0];
            quo_q   <= {quo_q[XLEN-2:0], ~diff[XLEN]};
            cnt_q   <= cnt_q - DIV_CNT_W'(1);
            valid_q <= (cnt_q == DIV_CNT_W'(1));
        end
    end

    assign q     = quo_q;
    assign r     = rem_q;
    assign valid = valid_q;

endmodule

// File: rtl/mips_cpu_hilo_ctrl.sv
// HI/LO sequencer: accepts HI/LO ops from execute, drives the external multiplier,
// runs the iterative divider and owns the architectural HI/LO registers.
// req_ready is low while a multi-cycle op runs so the pipeline stalls.
//   clk, rst_n          : clock, async active-low reset (aborts any op, clears HI/LO)
//   req                 : mips_cpu_hilo_ctrl_if.slave request bus
//   mul_a/mul_b/mul_sign: multiplier operands, held stable during MUL_WAIT
//   mul_out             : multiplier product, captured MUL_LAT edges after issue
//   hi, lo              : architectural HI/LO
// Optional feature macro: MIPS_CPU_MADD_EN (MADD/MADDU/MSUB/MSUBU accumulate into HI:LO).
module mips_cpu_hilo_ctrl
    import mips_cpu_hilo_pkg::*;
#(
    parameter int unsigned MUL_LAT  = 1,
    parameter int unsigned DIV_BITS = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    mips_cpu_hilo_ctrl_if.slave   req,
    output logic [XLEN-1:0]       mul_a,
    output logic [XLEN-1:0]       mul_b,
    output logic                  mul_sign,
    input  logic [2*XLEN-1:0]     mul_out,
    output logic [XLEN-1:0]       hi,
    output logic [XLEN-1:0]       lo
);

    hilo_state_t          state_q, state_d;
    logic [DIV_CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]      hi_q, hi_d, lo_q, lo_d;
    logic [XLEN-1:0]      mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic                 mul_sign_q, mul_sign_d;
    logic                 done_q, done_d;
    logic                 q_neg_q, q_neg_d, r_neg_q, r_neg_d;
    logic                 div0_q, div0_d;
`ifdef MIPS_CPU_MADD_EN
    logic                 acc_q, acc_d, sub_q, sub_d;
`endif
    logic                 div_start;
    logic [XLEN-1:0]      div_a, div_b, div_q, div_r;
    logic                 div_valid;
    logic                 accept;
    logic                 sgn;
    logic [XLEN-1:0]      rd_data_c;
    logic [2*XLEN-1:0]    hilo_new;

    mips_cpu_divider #(.DIV_BITS(DIV_BITS)) u_div (
        .clk   (clk),
        .rst_n (rst_n),
        .start (div_start),
        .a     (div_a),
        .b     (div_b),
        .q     (div_q),
        .r     (div_r),
        .valid (div_valid)
    );

    // State register and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_sign_q <= 1'b0;
            done_q     <= 1'b0;
            q_neg_q    <= 1'b0;
            r_neg_q    <= 1'b0;
            div0_q     <= 1'b0;
`ifdef MIPS_CPU_MADD_EN
            acc_q      <= 1'b0;
            sub_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_sign_q <= mul_sign_d;
            done_q     <= done_d;
            q_neg_q    <= q_neg_d;
            r_neg_q    <= r_neg_d;
            div0_q     <= div0_d;
`ifdef MIPS_CPU_MADD_EN
            acc_q      <= acc_d;
            sub_q      <= sub_d;
`endif
        end
    end

    // Next-state, register updates and the combinational MF read port.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        mul_a_d    = mul_a_q;
        mul_b_d    = mul_b_q;
        mul_sign_d = mul_sign_q;
        done_d     = 1'b0;
        q_neg_d    = q_neg_q;
        r_neg_d    = r_neg_q;
        div0_d     = div0_q;
`ifdef MIPS_CPU_MADD_EN
        acc_d      = acc_q;
        sub_d      = sub_q;
`endif
        div_start  = 1'b0;
        div_a      = '0;
        div_b      = '0;
        rd_data_c  = '0;
        sgn        = 1'b0;
        hilo_new   = mul_out;
        accept     = req.req_valid && (state_q == IDLE);

        case (state_q)
            IDLE: begin
                if (accept) begin
                    case (req.req_op)
                        MFHI: rd_data_c = hi_q;
                        MFLO: rd_data_c = lo_q;
                        MTHI: hi_d = req.rs_val;
                        MTLO: lo_d = req.rs_val;
                        MULT, MULTU: begin
                            mul_a_d    = req.rs_val;
                            mul_b_d    = req.rt_val;
                            mul_sign_d = (req.req_op == MULT);
                            cnt_d      = DIV_CNT_W'(MUL_LAT);
                            state_d    = MUL_WAIT;
`ifdef MIPS_CPU_MADD_EN
                            acc_d      = 1'b0;
                            sub_d      = 1'b0;
`endif
                        end
`ifdef MIPS_CPU_MADD_EN
                        MADD, MADDU, MSUB, MSUBU: begin
                            mul_a_d    = req.rs_val;
                            mul_b_d    = req.rt_val;
                            mul_sign_d = (req.req_op == MADD) || (req.req_op == MSUB);
                            cnt_d      = DIV_CNT_W'(MUL_LAT);
                            state_d    = MUL_WAIT;
                            acc_d      = 1'b1;
                            sub_d      = (req.req_op == MSUB) || (req.req_op == MSUBU);
                        end
`endif
                        DIV, DIVU: begin
                            // Divider sees magnitudes; result signs are restored in DIV_FIN.
                            sgn     = (req.req_op == DIV);
                            q_neg_d = sgn && (req.rs_val[XLEN-1] ^ req.rt_val[XLEN-1]);
                            r_neg_d = sgn && req.rs_val[XLEN-1];
                            if (req.rt_val == '0) begin
                                div0_d  = 1'b1;
                                state_d = DIV_FIN;
                            end else begin
                                div0_d    = 1'b0;
                                div_start = 1'b1;
                                div_a     = mag(req.rs_val, sgn);
                                div_b     = mag(req.rt_val, sgn);
                                cnt_d     = DIV_CNT_W'(DIV_BITS);
                                state_d   = DIV_RUN;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL_WAIT: begin
                cnt_d = cnt_q - DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(1)) begin
`ifdef MIPS_CPU_MADD_EN
                    if (acc_q) begin
                        hilo_new = sub_q ? ({hi_q, lo_q} - mul_out) : ({hi_q, lo_q} + mul_out);
                    end
`endif
                    hi_d    = hilo_new[2*XLEN-1:XLEN];
                    lo_d    = hilo_new[XLEN-1:0];
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            DIV_RUN: begin
                cnt_d = cnt_q - DIV_CNT_W'(1);
                if (cnt_q == DIV_CNT_W'(1)) begin
                    state_d = DIV_FIN;
                end
            end
            DIV_FIN: begin
                // Divide by zero leaves HI/LO untouched but still signals completion.
                if (!div0_q && div_valid) begin
                    lo_d = q_neg_q ? -div_q : div_q;
                    hi_d = r_neg_q ? -div_r : div_r;
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign req.req_ready = (state_q == IDLE);
    assign req.rd_data   = rd_data_c;
    assign req.done      = done_q;
    assign mul_a         = mul_a_q;
    assign mul_b         = mul_b_q;
    assign mul_sign      = mul_sign_q;
    assign hi            = hi_q;
    assign lo            = lo_q;

endmodule

// File: tb/tb_mips_cpu_hilo_ctrl.sv
// Scoreboard bench for mips_cpu_hilo_ctrl: stimulus pushes expected HI/LO and
// MF read data from a plain-arithmetic model; a negedge monitor pops and compares.
module tb_mips_cpu_hilo_ctrl;
    import mips_cpu_hilo_pkg::*;

    localparam int unsigned MUL_LAT  = 1;
    localparam int unsigned DIV_BITS = 32;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hl_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] mul_a, mul_b, hi, lo;
    logic        mul_sign;
    logic [63:0] mul_out;

    mips_cpu_hilo_ctrl_if bus();

    mips_cpu_hilo_ctrl #(.MUL_LAT(MUL_LAT), .DIV_BITS(DIV_BITS)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus),
        .mul_a    (mul_a),
        .mul_b    (mul_b),
        .mul_sign (mul_sign),
        .mul_out  (mul_out),
        .hi       (hi),
        .lo       (lo)
    );

    hl_t         done_exp[$];
    logic [31:0] rd_exp[$];
    int          tests = 0;
    int          fails = 0;
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // 32x32 -> 64 product, signed or unsigned.
    function automatic logic [63:0] mul_model(input logic [31:0] a, input logic [31:0] b, input logic s);
        longint sa, sb;
        if (s) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'd0, a});
            sb = longint'({32'd0, b});
        end
        return sa * sb;
    endfunction

    // External single-stage multiplier: product of the held operands.
    assign mul_out = mul_model(mul_a, mul_b, mul_sign);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: update HI/LO and push expected responses.
    task automatic model_issue(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b,
                               output bit multi, output int lat);
        longint sa, sb, q, r;
        hl_t    e;
        multi = 1'b0;
        lat   = 0;
        case (op)
            MULT, MULTU: begin
                {m_hi, m_lo} = mul_model(a, b, op == MULT);
                multi = 1'b1;
                lat   = int'(MUL_LAT) + 1;
            end
            DIV, DIVU: begin
                multi = 1'b1;
                if (b == 32'd0) begin
                    lat = 2;
                end else begin
                    lat = int'(DIV_BITS) + 2;
                    if (op == DIV) begin
                        sa = longint'($signed(a));
                        sb = longint'($signed(b));
                    end else begin
                        sa = longint'({32'd0, a});
                        sb = longint'({32'd0, b});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    m_lo = q[31:0];
                    m_hi = r[31:0];
                end
            end
`ifdef MIPS_CPU_MADD_EN
            MADD, MADDU, MSUB, MSUBU: begin
                if (op == MSUB || op == MSUBU)
                    {m_hi, m_lo} = {m_hi, m_lo} - mul_model(a, b, op == MSUB);
                else
                    {m_hi, m_lo} = {m_hi, m_lo} + mul_model(a, b, op == MADD);
                multi = 1'b1;
                lat   = int'(MUL_LAT) + 1;
            end
`endif
            MTHI: m_hi = a;
            MTLO: m_lo = a;
            MFHI: rd_exp.push_back(m_hi);
            MFLO: rd_exp.push_back(m_lo);
            default: ;
        endcase
        if (multi) begin
            e.hi = m_hi;
            e.lo = m_lo;
            done_exp.push_back(e);
        end
    endtask

    // Issue one op at posedge+1; for multi-cycle ops wait (bounded) for done.
    task automatic do_op(input hilo_op_t op, input logic [31:0] a, input logic [31:0] b);
        bit multi;
        int lat;
        int edges;
        bit ready_low;
        model_issue(op, a, b, multi, lat);
        check("ready_at_issue", 64'(bus.req_ready), 64'(1));
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.rs_val    = a;
        bus.rt_val    = b;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        bus.rs_val    = $urandom;
        bus.rt_val    = $urandom;
        if (multi) begin
            edges     = 1;
            ready_low = 1'b1;
            while (!bus.done && edges < 200) begin
                if (bus.req_ready) ready_low = 1'b0;
                @(posedge clk); #1;
                edges++;
            end
            check("latency", 64'(edges), 64'(lat));
            check("ready_low_busy", 64'(ready_low), 64'(1));
            check("ready_after_done", 64'(bus.req_ready), 64'(1));
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    // Monitor: compares every done pulse and every accepted request's rd_data.
    always @(negedge clk) begin
        hl_t e;
        if (rst_n) begin
            if (bus.done) begin
                if (done_exp.size() == 0) begin
                    check("unexpected_done", 64'(1), 64'(0));
                end else begin
                    e = done_exp.pop_front();
                    check("hi", 64'(hi), 64'(e.hi));
                    check("lo", 64'(lo), 64'(e.lo));
                end
            end
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_op == MFHI || bus.req_op == MFLO) begin
                    if (rd_exp.size() == 0)
                        check("unexpected_mf", 64'(1), 64'(0));
                    else
                        check("rd_data", 64'(bus.rd_data), 64'(rd_exp.pop_front()));
                end else begin
                    check("rd_data_zero", 64'(bus.rd_data), 64'(0));
                end
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL timeout: simulation did not finish, got running expected finished");
        fails++;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $fatal(1, "timeout");
    end

    initial begin
        bit multi;
        int lat;
        int edges;
        hilo_op_t op;
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_op    = MULT;
        bus.rs_val    = '0;
        bus.rt_val    = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_hi", 64'(hi), 64'(0));
        check("rst_lo", 64'(lo), 64'(0));
        check("rst_done", 64'(bus.done), 64'(0));
        check("rst_ready", 64'(bus.req_ready), 64'(1));
        check("rst_mul_a", 64'(mul_a), 64'(0));
        check("rst_mul_b", 64'(mul_b), 64'(0));
        check("rst_mul_sign", 64'(mul_sign), 64'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Directed cases with hand-derived constants.
        do_op(MULT, 32'hFFFF_FFFE, 32'h0000_0003);
        check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
        check("mult_lo", 64'(lo), 64'hFFFF_FFFA);
        do_op(MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        check("multu_hi", 64'(hi), 64'hFFFF_FFFE);
        check("multu_lo", 64'(lo), 64'h0000_0001);
        do_op(DIV, 32'hFFFF_FFF9, 32'd2);
        check("div_lo", 64'(lo), 64'hFFFF_FFFD);
        check("div_hi", 64'(hi), 64'hFFFF_FFFF);
        do_op(DIVU, 32'd100, 32'd7);
        check("divu_lo", 64'(lo), 64'd14);
        check("divu_hi", 64'(hi), 64'd2);
        do_op(DIV, 32'h8000_0000, 32'hFFFF_FFFF);
        check("divovf_lo", 64'(lo), 64'h8000_0000);
        check("divovf_hi", 64'(hi), 64'd0);
        do_op(MTHI, 32'h11, 32'd0);
        do_op(MTLO, 32'h22, 32'd0);
        do_op(DIVU, 32'd5, 32'd0);
        check("div0_hi", 64'(hi), 64'h11);
        check("div0_lo", 64'(lo), 64'h22);
        do_op(MTHI, 32'hDEAD_BEEF, 32'd0);
        do_op(MFHI, 32'd0, 32'd0);

        // MFLO held by a stalled pipeline during a divide is taken only on return to IDLE.
        model_issue(DIVU, 32'd1000, 32'd10, multi, lat);
        bus.req_valid = 1'b1;
        bus.req_op    = DIVU;
        bus.rs_val    = 32'd1000;
        bus.rt_val    = 32'd10;
        @(posedge clk); #1;
        bus.req_op = MFLO;
        rd_exp.push_back(m_lo);
        edges = 1;
        while (!bus.done && edges < 200) begin
            @(posedge clk); #1;
            edges++;
        end
        check("stall_latency", 64'(edges), 64'(lat));
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        check("stall_lo", 64'(lo), 64'd100);

        // Reset in the middle of DIV_RUN aborts without a done pulse.
        model_issue(DIV, 32'h1234_5678, 32'd3, multi, lat);
        bus.req_valid = 1'b1;
        bus.req_op    = DIV;
        bus.rs_val    = 32'h1234_5678;
        bus.rt_val    = 32'd3;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("pre_abort_ready", 64'(bus.req_ready), 64'(0));
        rst_n = 1'b0;
        #1;
        done_exp.delete();
        m_hi = '0;
        m_lo = '0;
        check("abort_hi", 64'(hi), 64'(0));
        check("abort_lo", 64'(lo), 64'(0));
        check("abort_ready", 64'(bus.req_ready), 64'(1));
        check("abort_done", 64'(bus.done), 64'(0));
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        do_op(MFLO, 32'd0, 32'd0);

`ifdef MIPS_CPU_MADD_EN
        do_op(MTHI, 32'd0, 32'd0);
        do_op(MTLO, 32'd5, 32'd0);
        do_op(MADD, 32'd2, 32'd3);
        check("madd_lo", 64'(lo), 64'd11);
        check("madd_hi", 64'(hi), 64'd0);
        do_op(hilo_op_t'(OP_W'(13)), 32'hFFFF_FFFF, 32'd1);
        check("illegal_lo", 64'(lo), 64'd11);
`endif

        // Randomized traffic.
        for (int i = 0; i < 150; i++) begin
`ifdef MIPS_CPU_MADD_EN
            op = hilo_op_t'(OP_W'($urandom_range(0, 12)));
`else
            op = hilo_op_t'(OP_W'($urandom_range(0, 7)));
`endif
            do_op(op, rnd_val(), rnd_val());
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (5) @(posedge clk);
        #1;
        check("done_queue_drained", 64'(done_exp.size()), 64'(0));
        check("rd_queue_drained", 64'(rd_exp.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
